// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, reads a combinational instruction memory and
// presents each fetched word with its PC in a valid/ready output slot.
module instruction_fetch_unit #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] imem_address,
    output logic                  imem_read_en,
    input  logic [DATA_WIDTH-1:0] imem_instruction,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instruction,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  halted
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HALT  = 1'b1
    } state_t;

    // Targets above the last valid word are treated as out of range.
    localparam logic [ADDR_WIDTH-1:0] LP_LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_next;
    logic                  r_out_valid;
    logic                  w_out_valid_next;
    logic [DATA_WIDTH-1:0] r_out_instruction;
    logic [DATA_WIDTH-1:0] w_out_instruction_next;
    logic [ADDR_WIDTH-1:0] r_out_pc;
    logic [ADDR_WIDTH-1:0] w_out_pc_next;
    logic                  w_slot_free;
    logic                  w_fetch;

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_fetch     = (r_state == S_FETCH) && w_slot_free && !branch_taken;

    always_comb begin
        w_state_next           = r_state;
        w_pc_next              = r_pc;
        w_out_valid_next       = r_out_valid;
        w_out_instruction_next = r_out_instruction;
        w_out_pc_next          = r_out_pc;

        if (branch_taken) begin
            // Branch flushes the slot even if it was never accepted.
            w_out_valid_next = 1'b0;
            if (branch_target <= LP_LAST_ADDR) begin
                w_pc_next    = branch_target;
                w_state_next = S_FETCH;
            end else begin
                w_state_next = S_HALT;
            end
        end else if (w_fetch) begin
            w_out_instruction_next = imem_instruction;
            w_out_pc_next          = r_pc;
            w_out_valid_next       = 1'b1;
            if (r_pc == LP_LAST_ADDR) begin
                w_state_next = S_HALT;
            end else begin
                w_pc_next = r_pc + ADDR_WIDTH'(1);
            end
        end else if (r_out_valid && out_ready) begin
            w_out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state           <= S_FETCH;
            r_pc              <= '0;
            r_out_valid       <= 1'b0;
            r_out_instruction <= '0;
            r_out_pc          <= '0;
        end else begin
            r_state           <= w_state_next;
            r_pc              <= w_pc_next;
            r_out_valid       <= w_out_valid_next;
            r_out_instruction <= w_out_instruction_next;
            r_out_pc          <= w_out_pc_next;
        end
    end

    assign imem_address    = r_pc;
    assign imem_read_en    = w_fetch;
    assign out_valid       = r_out_valid;
    assign out_instruction = r_out_instruction;
    assign out_pc          = r_out_pc;
    assign halted          = (r_state == S_HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: per-cycle vector table for the free run,
// hand sequences for stall/branch/halt/reset, and a transfer scoreboard.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic [3:0]  imem_address;
    logic        imem_read_en;
    logic [31:0] imem_instruction;
    logic        branch_taken;
    logic [3:0]  branch_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [3:0]  out_pc;
    logic        halted;

    logic [31:0] mem [0:14];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]  pc;
        logic [31:0] ins;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic        rdy;
        logic        rden;
        logic        valid;
        logic        dchk;
        logic [3:0]  pc;
        logic [31:0] ins;
        logic        hlt;
    } vec_t;
    vec_t vt [17];

    instruction_fetch_unit #(
        .ADDR_WIDTH(4),
        .DATA_WIDTH(32),
        .MEM_DEPTH (15)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_address    (imem_address),
        .imem_read_en    (imem_read_en),
        .imem_instruction(imem_instruction),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .halted          (halted)
    );

    assign imem_instruction = (imem_address != 4'd15) ? mem[imem_address] : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic br, input logic [3:0] tgt);
        out_ready     = rdy;
        branch_taken  = br;
        branch_target = tgt;
    endtask

    task automatic chk_slot(input string name, input logic v, input logic [3:0] pc,
                            input logic [31:0] ins, input logic h);
        chk({name, "_valid"}, {31'b0, out_valid}, {31'b0, v});
        chk({name, "_pc"}, {28'b0, out_pc}, {28'b0, pc});
        chk({name, "_ins"}, out_instruction, ins);
        chk({name, "_halted"}, {31'b0, halted}, {31'b0, h});
    endtask

    task automatic push_range(input int lo, input int hi);
        exp_t e;
        for (int a = lo; a <= hi; a++) begin
            e.pc  = 4'(a);
            e.ins = mem[a];
            sbq.push_back(e);
        end
    endtask

    // Transfers happen where out_valid && out_ready at the edge; sample mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready && !branch_taken) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_transfer", {28'b0, out_pc}, 32'hFFFF_FFFF);
            end else begin
                e = sbq.pop_front();
                chk("sb_pc", {28'b0, out_pc}, {28'b0, e.pc});
                chk("sb_ins", out_instruction, e.ins);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[0] = 32'h8c0c0000; mem[1] = 32'h8c0d0001; mem[2] = 32'h8c0e0002;
        mem[3] = 32'h8c0f0003; mem[4] = 32'h018d4820; mem[5] = 32'h01cf5020;
        mem[6] = 32'h01494022; mem[7] = 32'hac080004;
        for (int a = 8; a < 15; a++) mem[a] = 32'h0;

        for (int k = 0; k < 15; k++) begin
            vt[k] = '{rdy: 1'b1, rden: 1'b1, valid: 1'b1, dchk: 1'b1,
                      pc: 4'(k), ins: mem[k], hlt: (k == 14)};
        end
        vt[15] = '{rdy: 1'b1, rden: 1'b0, valid: 1'b0, dchk: 1'b0, pc: 4'd0, ins: 32'h0, hlt: 1'b1};
        vt[16] = '{rdy: 1'b1, rden: 1'b0, valid: 1'b0, dchk: 1'b0, pc: 4'd0, ins: 32'h0, hlt: 1'b1};

        reset = 1'b1;
        drive(1'b0, 1'b0, 4'd0);
        #12;
        chk_slot("reset", 1'b0, 4'd0, 32'h0, 1'b0);
        chk("reset_addr", {28'b0, imem_address}, 32'h0);
        reset = 1'b0;
        #1;
        chk("reset_rden", {31'b0, imem_read_en}, 32'h1);

        // Free run over the whole image into HALT.
        push_range(0, 14);
        for (int i = 0; i < 17; i++) begin
            out_ready = vt[i].rdy;
            #1;
            chk($sformatf("run%0d_rden", i), {31'b0, imem_read_en}, {31'b0, vt[i].rden});
            tick();
            chk($sformatf("run%0d_valid", i), {31'b0, out_valid}, {31'b0, vt[i].valid});
            chk($sformatf("run%0d_halted", i), {31'b0, halted}, {31'b0, vt[i].hlt});
            if (vt[i].dchk) begin
                chk($sformatf("run%0d_pc", i), {28'b0, out_pc}, {28'b0, vt[i].pc});
                chk($sformatf("run%0d_ins", i), out_instruction, vt[i].ins);
            end
        end
        chk("run_sb_drained", sbq.size(), 0);

        // Restart at 0, then stall with word 2 in the slot.
        drive(1'b1, 1'b1, 4'd0);
        tick();
        chk_slot("restart", 1'b0, out_pc, out_instruction, 1'b0);
        push_range(0, 2);
        drive(1'b1, 1'b0, 4'd0);
        tick(); tick(); tick();
        chk_slot("pre_stall", 1'b1, 4'd2, mem[2], 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall%0d_rden", i), {31'b0, imem_read_en}, 32'h0);
            tick();
            chk_slot($sformatf("stall%0d", i), 1'b1, 4'd2, mem[2], 1'b0);
            chk($sformatf("stall%0d_addr", i), {28'b0, imem_address}, 32'd3);
        end
        out_ready = 1'b1;
        tick();
        chk_slot("post_stall", 1'b1, 4'd3, mem[3], 1'b0);

        // Branch while stalled: word 3 is flushed, target 6 after one bubble.
        drive(1'b0, 1'b1, 4'd6);
        tick();
        chk("brstall_flush", {31'b0, out_valid}, 32'h0);
        drive(1'b0, 1'b0, 4'd0);
        tick();
        chk_slot("brstall_tgt", 1'b1, 4'd6, mem[6], 1'b0);
        chk("brstall_sb_drained", sbq.size(), 0);

        // Out-of-range target halts without moving pc.
        drive(1'b0, 1'b1, 4'd15);
        tick();
        chk("oor_valid", {31'b0, out_valid}, 32'h0);
        chk("oor_halted", {31'b0, halted}, 32'h1);
        drive(1'b1, 1'b0, 4'd0);
        #1;
        chk("oor_rden", {31'b0, imem_read_en}, 32'h0);
        tick();
        chk("oor_hold_valid", {31'b0, out_valid}, 32'h0);
        chk("oor_hold_addr", {28'b0, imem_address}, 32'd7);
        drive(1'b0, 1'b1, 4'd4);
        tick();
        chk("resume_halted", {31'b0, halted}, 32'h0);
        drive(1'b0, 1'b0, 4'd0);
        tick();
        chk_slot("resume", 1'b1, 4'd4, mem[4], 1'b0);

        // Fetch the last word with a stalled slot, then branch out of HALT.
        drive(1'b0, 1'b1, 4'd14);
        tick();
        drive(1'b0, 1'b0, 4'd0);
        tick();
        chk_slot("last", 1'b1, 4'd14, mem[14], 1'b1);
        #1;
        chk("last_rden", {31'b0, imem_read_en}, 32'h0);
        tick();
        chk_slot("last_hold", 1'b1, 4'd14, mem[14], 1'b1);
        drive(1'b0, 1'b1, 4'd0);
        tick();
        chk("hbr_flush", {31'b0, out_valid}, 32'h0);
        chk("hbr_halted", {31'b0, halted}, 32'h0);
        drive(1'b0, 1'b0, 4'd0);
        tick();
        chk_slot("hbr_restart", 1'b1, 4'd0, mem[0], 1'b0);

        // Stream to pc 5, then reset between edges.
        push_range(0, 4);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk_slot("pre_reset", 1'b1, 4'd5, mem[5], 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_slot("async_reset", 1'b0, 4'd0, 32'h0, 1'b0);
        chk("async_reset_addr", {28'b0, imem_address}, 32'h0);
        #3;
        reset = 1'b0;
        push_range(0, 0);
        tick();
        chk_slot("post_reset", 1'b1, 4'd0, mem[0], 1'b0);
        tick();
        chk("final_sb_drained", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage that drives the instruction memory and delivers instructions downstream. It holds the program counter and issues address/read-enable to the 15-word, 4-bit-addressed, combinational-read instruction memory. It registers each returned word with its PC into an IF/ID output slot under a valid/ready handshake. It supports back-pressure stalls, branch redirects with flush, and halting at the end of the memory image.

## Interface
- ADDR_WIDTH, 4, PC / memory address width
- DATA_WIDTH, 32, instruction width
- MEM_DEPTH, 15, number of valid words; the last valid address is MEM_DEPTH-1
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high
- imem_address  output  ADDR_WIDTH  address to instruction memory, always equals pc
- imem_read_en  output  1  read enable to instruction memory
- imem_instruction  input  DATA_WIDTH  combinational read data from memory
- branch_taken  input  1  redirect request, sampled on rising edge
- branch_target  input  ADDR_WIDTH  redirect address
- out_valid  output  1  output slot holds an instruction
- out_ready  input  1  downstream accepts the slot this cycle
- out_instruction  output  DATA_WIDTH  registered instruction
- out_pc  output  ADDR_WIDTH  address the instruction was fetched from
- halted  output  1  fetch stopped; high in HALT state

## Operation
- States: FETCH, HALT. Reset enters FETCH.
- Define slot_free = !out_valid || out_ready.
- Define fetch = (state==FETCH) && slot_free && !branch_taken.
- imem_read_en = fetch, driven combinationally. imem_address = pc.
- **Fetch:** on a rising edge with fetch=1:
  - out_instruction <= imem_instruction, out_pc <= pc, out_valid <= 1.
  - If pc == MEM_DEPTH-1: go to HALT, pc unchanged.
  - Otherwise pc <= pc+1.
- **Consume without fetch:** out_valid && out_ready && !fetch → out_valid <= 0 (covers draining in HALT).
- **Stall:** out_valid && !out_ready && !branch_taken → pc, out_*, and state all hold; imem_read_en=0.
- **Branch** (any state; priority over stall and fetch):
  - out_valid <= 0. The slot is flushed even if it was never accepted.
  - If branch_target < MEM_DEPTH: pc <= branch_target, state <= FETCH.
  - Otherwise: state <= HALT, pc unchanged.
  - No fetch occurs on the branch cycle.
- **HALT:** imem_read_en=0 and no new fetches. Only a branch or reset leaves HALT. A pending slot still drains via out_ready.
- **Arithmetic:** pc is ADDR_WIDTH wide. pc+1 never wraps, because HALT is entered at MEM_DEPTH-1.

## Timing
- **Reset values:**
  - pc=0, state=FETCH
  - out_valid=0, out_instruction=0, out_pc=0, halted=0
  - imem_address=0, imem_read_en=1 (combinational, once reset is released and branch_taken=0)
- **Reset mid-operation:** all registers clear immediately, without waiting for a clock edge. Fetch restarts at address 0 on the first edge after deassertion.
- **Latency:** the word at pc=A, fetched at edge N, appears on out_instruction/out_pc with out_valid=1 after edge N.
- **Throughput:** 1 instruction/cycle while out_ready=1.
- **Handshake:** a transfer occurs on an edge where out_valid && out_ready. out_instruction and out_pc must not change while out_valid && !out_ready, except on a branch flush.
- **Branch timing:** branch_taken at edge N gives out_valid=0 after N. The target word is fetched at edge N+1 and is valid after N+1, so there is a one-cycle bubble.
- **halted** rises on the edge that fetches address MEM_DEPTH-1, together with that word's out_valid.

## Test plan
- **Free run:** reset, out_ready=1, memory loaded 0..7 = 8c0c0000, 8c0d0001, 8c0e0002, 8c0f0003, 018d4820, 01cf5020, 01494022, ac080004, and 8..14 = 0.
  - out_valid=1 from edge 1.
  - out_pc = 0,1,…,14 on consecutive edges, with out_instruction matching each word.
  - halted=1 after edge 15, imem_read_en=0 thereafter, out_valid drops after edge 16.
- **Stall:** drop out_ready while out_pc=2 (8c0e0002) for 3 cycles.
  - Outputs hold 2 / 8c0e0002, pc holds 3, imem_read_en=0.
  - Raise out_ready: next outputs are 3 / 8c0f0003, with no duplicate or skipped word.
- **Branch during stall:** out_valid=1, out_ready=0, branch_taken=1, branch_target=6.
  - Slot flushed (out_valid=0) after the edge.
  - Next edge: out_pc=6, out_instruction=01494022.
- **Out-of-range branch:** branch_target=15.
  - halted=1, out_valid=0, no further fetch.
  - A subsequent branch_target=4 resumes with out_pc=4, out_instruction=018d4820, halted=0.
- **Branch from HALT after the last fetch:** with out_valid=1 and out_ready=0 at pc 14, branch_target=0.
  - Slot flushed, restart: out_pc=0, out_instruction=8c0c0000.
- **Async reset mid-stream:** assert reset between clock edges while out_pc=5.
  - All outputs 0 and out_valid=0 immediately, without waiting for an edge.
  - After release, the first edge yields out_pc=0.
